div_16x8_seq: RTL and testbench

DIV_16X8_SEQ -- requirements
Module: div_16x8_seq

---
 rtl/div_pkg.sv | 32 +++
 rtl/div_16x8_seq_if.sv | 43 ++++
 rtl/div_step.sv | 41 ++++
 rtl/div_16x8_seq.sv | 127 ++++++++++++
 tb/tb_div_16x8_seq.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared definitions for the sequential 16/8 restoring divider:
//   N_W_DEF / D_W_DEF : default dividend/quotient and divisor/remainder widths
//   state_e           : controller states (IDLE, CALC, DONE)
//   cnt_width()       : iteration counter width for a given dividend width
//   CNT_W             : counter width at the default dividend width
//   DZ_Q              : divide-by-zero quotient (all ones, truncated at use)
// -----------------------------------------------------------------------------
package div_pkg;

   localparam int N_W_DEF = 16;
   localparam int D_W_DEF = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_e;

   // Counter must hold N_W-1 (the index of the first, most significant step).
   function automatic int cnt_width(input int n_w);
      return (n_w > 1) ? $clog2(n_w) : 1;
   endfunction

   localparam int CNT_W = cnt_width(N_W_DEF);

   // Wide enough for any practical N_W; a width cast at the use site keeps
   // it all ones.
   localparam logic [63:0] DZ_Q = '1;

endpackage : div_pkg

// File: rtl/div_16x8_seq_if.sv
// -----------------------------------------------------------------------------
// div_16x8_seq_if
// Operand/result handshake bundle of the sequential divider.
//   in_valid  : operand pair A/B presented          (master -> slave)
//   in_ready  : divider can accept operands         (slave  -> master)
//   A         : unsigned dividend, N_W bits         (master -> slave)
//   B         : unsigned divisor, D_W bits          (master -> slave)
//   out_valid : result presented                    (slave  -> master)
//   out_ready : consumer accepts the result         (master -> slave)
//   Q         : quotient, N_W bits                  (slave  -> master)
//   R         : remainder, D_W bits                 (slave  -> master)
//   dz        : divide-by-zero flag, qualified by out_valid
// -----------------------------------------------------------------------------
interface div_16x8_seq_if
   import div_pkg::*;
#(
   parameter int N_W = N_W_DEF,
   parameter int D_W = D_W_DEF
);

   logic           in_valid;
   logic           in_ready;
   logic [N_W-1:0] A;
   logic [D_W-1:0] B;
   logic           out_valid;
   logic           out_ready;
   logic [N_W-1:0] Q;
   logic [D_W-1:0] R;
   logic           dz;

   // Divider side.
   modport slave (
      input  in_valid, A, B, out_ready,
      output in_ready, out_valid, Q, R, dz
   );

   // Producer/consumer side.
   modport master (
      output in_valid, A, B, out_ready,
      input  in_ready, out_valid, Q, R, dz
   );

endinterface : div_16x8_seq_if

// File: rtl/div_step.sv
// -----------------------------------------------------------------------------
// div_step
// One combinational restoring-division step, usable as a stage of an
// unrolled divider as well as the datapath of the sequential one.
//   rem_i : partial remainder, D_W+1 bits (always < divisor on entry)
//   bit_i : next dividend bit, shifted in at the LSB
//   div_i : divisor, D_W bits
//   rem_o : new partial remainder, D_W+1 bits
//   q_o   : quotient bit produced by this step
// -----------------------------------------------------------------------------
module div_step
   import div_pkg::*;
#(
   parameter int D_W = D_W_DEF
) (
   input  logic [D_W:0]   rem_i,
   input  logic           bit_i,
   input  logic [D_W-1:0] div_i,
   output logic [D_W:0]   rem_o,
   output logic           q_o
);

   // One bit wider than the remainder so the shift can never lose a bit,
   // whatever the caller feeds in.
   logic [D_W+1:0] shifted;
   logic [D_W+1:0] div_ext;

   assign shifted = {rem_i, bit_i};
   assign div_ext = {2'b00, div_i};

   // NOTE: every output gets a value before any branch, so no latch is inferred.
   always_comb begin
      rem_o = (D_W+1)'(shifted);
      q_o   = 1'b0;
      if (shifted >= div_ext) begin
         rem_o = (D_W+1)'(shifted - div_ext);
         q_o   = 1'b1;
      end
   end

endmodule : div_step

// File: rtl/div_16x8_seq.sv
// -----------------------------------------------------------------------------
// div_16x8_seq
// Sequential unsigned restoring divider, one quotient bit per clock, MSB
// first. Operands are taken on an in_valid/in_ready handshake, the result is
// held on out_valid until out_ready. One operation in flight at a time.
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : div_16x8_seq_if.slave (in_valid/in_ready/A/B, out_valid/out_ready/
//         Q/R/dz)
// Latency: out_valid rises 16 edges after acceptance (1 edge for B == 0).
// -----------------------------------------------------------------------------
module div_16x8_seq
   import div_pkg::*;
#(
   parameter int N_W = N_W_DEF,
   parameter int D_W = D_W_DEF
) (
   input  logic           clk,
   input  logic           rst,
   div_16x8_seq_if.slave  bus
);

   localparam int CW = cnt_width(N_W);

   state_e         state_q;
   logic [N_W-1:0] a_q;          // dividend in, quotient bits shifted in at LSB
   logic [D_W-1:0] b_q;
   logic [D_W:0]   rem_q;
   logic [CW-1:0]  cnt_q;
   logic [N_W-1:0] q_q;
   logic [D_W-1:0] r_q;
   logic           dz_q;
   logic           out_valid_q;

   logic [D_W:0]   rem_d;
   logic           q_bit;
   logic [N_W-1:0] a_d;

   div_step #(
      .D_W   (D_W)
   ) u_step (
      .rem_i (rem_q),
      .bit_i (a_q[N_W-1]),
      .div_i (b_q),
      .rem_o (rem_d),
      .q_o   (q_bit)
   );

   // The dividend bit consumed this step leaves at the MSB while the new
   // quotient bit enters at the LSB; after N_W steps a_q is the quotient.
   assign a_d = {a_q[N_W-2:0], q_bit};

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         rem_q       <= '0;
         cnt_q       <= '0;
         q_q         <= '0;
         r_q         <= '0;
         dz_q        <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (bus.in_valid) begin
                  a_q     <= bus.A;
                  b_q     <= bus.B;
                  rem_q   <= '0;
                  state_q <= CALC;
                  if (bus.B == '0) begin
                     // A single pass through CALC commits the fixed
                     // divide-by-zero result, so out_valid rises one edge
                     // after acceptance under the same counting as the
                     // N_W-edge normal path.
                     cnt_q <= '0;
                     dz_q  <= 1'b1;
                  end else begin
                     cnt_q <= CW'(N_W - 1);
                     dz_q  <= 1'b0;
                  end
               end
            end

            CALC: begin
               a_q   <= a_d;
               rem_q <= rem_d;
               cnt_q <= cnt_q - CW'(1);
               if (cnt_q == '0) begin
                  state_q     <= DONE;
                  out_valid_q <= 1'b1;
                  if (dz_q) begin
                     // a_q is still the untouched dividend on this pass.
                     q_q <= N_W'(DZ_Q);
                     r_q <= a_q[D_W-1:0];
                  end else begin
                     q_q <= a_d;
                     r_q <= rem_d[D_W-1:0];
                  end
               end
            end

            DONE: begin
               if (bus.out_ready) begin
                  state_q     <= IDLE;
                  out_valid_q <= 1'b0;
               end
            end

            default: begin
               state_q     <= IDLE;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = out_valid_q;
   assign bus.Q         = q_q;
   assign bus.R         = r_q;
   assign bus.dz        = dz_q;

endmodule : div_16x8_seq

// File: tb/tb_div_16x8_seq.sv
// -----------------------------------------------------------------------------
// tb_div_16x8_seq
// Directed self-checking bench for div_16x8_seq. Inputs are driven and
// outputs sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_div_16x8_seq;

   logic clk;
   logic rst;
   int   n_vec;
   int   n_err;

   div_16x8_seq_if #(.N_W(16), .D_W(8)) bus ();

   div_16x8_seq #(
      .N_W (16),
      .D_W (8)
   ) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one operand pair; returns just after the acceptance edge.
   task automatic start_op(input logic [15:0] a, input logic [7:0] b, input string tag);
      int waited;
      waited = 0;
      while (!bus.in_ready && waited < 40) begin
         tick();
         waited++;
      end
      check({tag, " in_ready before accept"}, 32'(bus.in_ready), 32'd1);
      bus.in_valid = 1'b1;
      bus.A        = a;
      bus.B        = b;
      tick();
      bus.in_valid = 1'b0;
      bus.A        = 16'($urandom);
      bus.B        = 8'($urandom);
   endtask

   // Count edges from acceptance until out_valid is seen.
   task automatic wait_result(input int exp_lat, input string tag);
      int lat;
      lat = 0;
      while (!bus.out_valid && lat < 40) begin
         tick();
         lat++;
      end
      check({tag, " latency"}, 32'(lat), 32'(exp_lat));
   endtask

   // Check the presented result, then hand it off (out_ready assumed high).
   task automatic take_result(input logic [15:0] q, input logic [7:0] r, input logic dz,
                              input string tag);
      check({tag, " Q"},  32'(bus.Q),  32'(q));
      check({tag, " R"},  32'(bus.R),  32'(r));
      check({tag, " dz"}, 32'(bus.dz), 32'(dz));
      tick();
      check({tag, " out_valid after handoff"}, 32'(bus.out_valid), 32'd0);
      check({tag, " in_ready after handoff"},  32'(bus.in_ready),  32'd1);
   endtask

   initial begin
      int seen;
      n_vec         = 0;
      n_err         = 0;
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.A         = '0;
      bus.B         = '0;
      bus.out_ready = 1'b1;

      // Reset state.
      tick();
      tick();
      check("reset out_valid", 32'(bus.out_valid), 32'd0);
      check("reset in_ready",  32'(bus.in_ready),  32'd1);
      check("reset Q",         32'(bus.Q),         32'd0);
      check("reset R",         32'(bus.R),         32'd0);
      check("reset dz",        32'(bus.dz),        32'd0);
      rst = 1'b0;
      tick();

      // Basic division, 16-edge latency.
      start_op(16'd100, 8'd7, "100/7");
      check("100/7 in_ready in CALC", 32'(bus.in_ready), 32'd0);
      wait_result(16, "100/7");
      take_result(16'd14, 8'd2, 1'b0, "100/7");

      // Extremes.
      start_op(16'd65535, 8'd255, "65535/255");
      wait_result(16, "65535/255");
      take_result(16'd257, 8'd0, 1'b0, "65535/255");

      start_op(16'd0, 8'd5, "0/5");
      wait_result(16, "0/5");
      take_result(16'd0, 8'd0, 1'b0, "0/5");

      // Divide by zero.
      start_op(16'h1234, 8'd0, "1234/0");
      wait_result(1, "1234/0");
      take_result(16'hFFFF, 8'h34, 1'b1, "1234/0");

      // Result held under back-pressure; second request ignored meanwhile.
      bus.out_ready = 1'b0;
      start_op(16'd1000, 8'd3, "1000/3");
      wait_result(16, "1000/3");
      for (int i = 0; i < 5; i++) begin
         check("1000/3 hold Q",         32'(bus.Q),         32'd333);
         check("1000/3 hold R",         32'(bus.R),         32'd1);
         check("1000/3 hold out_valid", 32'(bus.out_valid), 32'd1);
         check("1000/3 hold in_ready",  32'(bus.in_ready),  32'd0);
         if (i == 1) begin
            bus.in_valid = 1'b1;
            bus.A        = 16'd9;
            bus.B        = 8'd2;
         end
         if (i == 4) bus.in_valid = 1'b0;
         tick();
      end
      bus.out_ready = 1'b1;
      take_result(16'd333, 8'd1, 1'b0, "1000/3");
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         if (bus.out_valid || !bus.in_ready) seen++;
         tick();
      end
      check("ignored second request", 32'(seen), 32'd0);

      // Back-to-back operations.
      start_op(16'd50000, 8'd200, "50000/200");
      wait_result(16, "50000/200");
      take_result(16'd250, 8'd0, 1'b0, "50000/200");
      start_op(16'd7, 8'd9, "7/9");
      wait_result(16, "7/9");
      take_result(16'd0, 8'd7, 1'b0, "7/9");

      // Reset during the 8th CALC cycle aborts the operation.
      start_op(16'hBEEF, 8'h11, "abort");
      repeat (7) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("abort out_valid", 32'(bus.out_valid), 32'd0);
      check("abort in_ready",  32'(bus.in_ready),  32'd1);
      check("abort Q",         32'(bus.Q),         32'd0);
      check("abort R",         32'(bus.R),         32'd0);
      check("abort dz",        32'(bus.dz),        32'd0);
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         if (bus.out_valid) seen++;
         tick();
      end
      check("abort no out_valid", 32'(seen), 32'd0);

      start_op(16'd255, 8'd16, "255/16");
      wait_result(16, "255/16");
      take_result(16'd15, 8'd15, 1'b0, "255/16");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_div_16x8_seq
